// File: rtl/lms_pkg.sv
// Shared constants and types for the LUT sample streamer feeding the LMS datapath.
package lms_pkg;

  localparam int DEPTH  = 500;
  localparam int AW     = 10;
  localparam int DW     = 16;
  localparam int OFFSET = 7500;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stream_state_t;

  // "ref" is a reserved word, so the 30 MHz reference channel is called reference
  typedef struct packed {
    logic [DW-1:0] desired;
    logic [DW-1:0] reference;
    logic [DW-1:0] noisy;
  } sample_t;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/lut_stream_outreg.sv
// One-entry valid/ready holding register for a LUT sample triple plus last flag.
// With LUT_STREAM_SIGNED_EN defined, samples are re-centred to two's complement around OFFSET.
module lut_stream_outreg
  import lms_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  sample_t i_data,
  input  logic    i_last,
  input  logic    i_ready,
  output logic    o_can_load,
  output logic    o_valid,
  output sample_t o_data,
  output logic    o_last
);

  logic    r_valid;
  logic    r_last;
  sample_t r_data;
  sample_t w_data;

`ifdef LUT_STREAM_SIGNED_EN
  localparam logic [DW-1:0] OFFSET_CODE = DW'(OFFSET);

  always_comb begin
    w_data.desired   = i_data.desired   - OFFSET_CODE;
    w_data.reference = i_data.reference - OFFSET_CODE;
    w_data.noisy     = i_data.noisy     - OFFSET_CODE;
  end
`else
  assign w_data = i_data;
`endif

  // A new beat may enter when the slot is empty or its occupant leaves this cycle
  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_last  <= i_last;
      r_data  <= w_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/lut_sample_streamer.sv
// Walks the sample LUT cyclically from a start address and streams the triples out.
// Optional build macro LUT_STREAM_SIGNED_EN (handled in lut_stream_outreg) re-centres samples.
module lut_sample_streamer
  import lms_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [15:0]   num_samples,
  output logic [AW-1:0] lut_addr,
  input  logic [DW-1:0] lut_sine_2,
  input  logic [DW-1:0] lut_sine_30,
  input  logic [DW-1:0] lut_noisy,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_desired,
  output logic [DW-1:0] m_ref,
  output logic [DW-1:0] m_noisy,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  stream_state_t r_state;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_remaining;
  logic          r_busy;
  logic          r_done;
  logic          w_can_load;
  logic          w_load;
  logic          w_last_beat;
  sample_t       w_lut;
  sample_t       w_out;

  assign w_lut       = {lut_sine_2, lut_sine_30, lut_noisy};
  assign w_load      = (r_state == RUN) && w_can_load;
  assign w_last_beat = (r_remaining == 16'd1);

  // A load and a stop in the same cycle both take effect: the beat is captured, then DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_remaining <= num_samples;
            r_addr      <= (start_addr > LAST_ADDR) ? '0 : start_addr;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_load) begin
            r_addr <= next_addr(r_addr);
            if (r_remaining != '0) r_remaining <= r_remaining - 16'd1;
          end
          if ((w_load && w_last_beat) || stop) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_can_load) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  lut_stream_outreg u_outreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_data     (w_lut),
    .i_last     (w_load && w_last_beat),
    .i_ready    (m_ready),
    .o_can_load (w_can_load),
    .o_valid    (m_valid),
    .o_data     (w_out),
    .o_last     (m_last)
  );

  assign lut_addr  = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign m_desired = w_out.desired;
  assign m_ref     = w_out.reference;
  assign m_noisy   = w_out.noisy;

endmodule

// File: doc/lut_sample_streamer.md
# lut_sample_streamer

Sequencer and stream source that reads the sine/noisy sample LUT for the LMS datapath. Given a start address and sample count, it walks the LUT address space cyclically with wrap at DEPTH-1. It registers each addressed triple (2 MHz desired, 30 MHz reference, noisy primary) and presents it on a valid/ready stream to the LMS filter core.

## Interface
- DEPTH, 500, number of LUT entries; addresses 0..DEPTH-1
- AW, 10, LUT address width
- DW, 16, sample width
- OFFSET, 7500, LUT mid-scale code, used only by the signed option
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- stop  in  1  end a continuous or counted run early; sampled in RUN
- start_addr  in  AW  first LUT address; values >= DEPTH are treated as 0
- num_samples  in  16  beats to emit; 0 = continuous until stop
- lut_addr  out  AW  registered address to the LUT
- lut_sine_2 / lut_sine_30 / lut_noisy  in  DW  combinational LUT read data for lut_addr
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer accepts beat when m_valid && m_ready
- m_desired / m_ref / m_noisy  out  DW  registered sine_2 / sine_30 / noisy samples
- m_last  out  1  final beat of a counted run
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a run fully drains

## Operation
- FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE, start=1: latch the count into a 16-bit remaining counter, load lut_addr from start_addr (clamped), go to RUN.
- RUN, load condition: the output register is empty, or m_valid && m_ready.
  - On load: capture the three LUT inputs, set m_valid.
  - lut_addr advances by 1, with DEPTH-1 -> 0.
  - remaining decrements if non-zero.
- Counted run: the load with remaining==1 sets m_last=1 and moves to DRAIN.
- RUN, stop=1: no further loads, go to DRAIN. A held beat is still delivered; m_last is not set retroactively. stop and a load in the same cycle: the load completes first.
- DRAIN: when the register empties, or is already empty, pulse done and go to IDLE. lut_addr holds its value.
- start while busy is ignored. stop in IDLE is ignored.
- Under backpressure (m_ready=0) the m_* outputs and lut_addr hold stable. No address is skipped or repeated.
- Reset values: state IDLE, lut_addr 0, m_valid 0, m_last 0, m_* data 0, busy 0, done 0, remaining 0.
- rst at any time, including mid-run or mid-DRAIN, aborts the run. No done pulse is issued.

## Timing
- start sampled at edge E0. lut_addr = start_addr after E0. First beat registered at E1, so m_valid=1 in the cycle after E1. Latency from start to first valid is 2 cycles.
- Throughput is 1 beat/cycle with m_ready held high. No bubbles at address wrap.
- done asserts the cycle after the edge on which the last beat is accepted.
- m_last and m_valid drop at the same edge the last beat is accepted.

## Configuration
- LUT_STREAM_SIGNED_EN defined: each captured sample = LUT code - OFFSET, as DW-bit two's complement. Examples: 14999 -> 7499, 0 -> -7500, 7500 -> 0.
- Not defined: raw unsigned LUT codes pass through unchanged.
- Port widths are identical in both builds.

## Structure
- Shared package lms_pkg holds:
  - DEPTH, AW, DW, OFFSET constants
  - stream_state_t enum {IDLE, RUN, DRAIN}
  - a sample triple struct typedef {desired, ref, noisy}
- One sub-module, lut_stream_outreg: a one-entry valid/ready holding register for the triple with last flag. It exposes a load-enable for the FSM and contains the optional offset subtraction.

## Test plan
- start_addr=0, num_samples=3, m_ready=1:
  - m_desired 7500, 7688, 7877
  - m_noisy 7500, 8977, 10259
  - m_ref 7500, 10266, 12642
  - m_last on beat 3; done one cycle later.
- start_addr=498, num_samples=4: addresses 498, 499, 0, 1. m_desired 7311, 7499, 7500, 7688; m_noisy 6022, 7499, 7500, 8977 (wrap with no bubble).
- num_samples=10, m_ready low for 5 cycles after beat 2: m_valid stays high, data stays 7877/10259, lut_addr stable. Beats 3..10 then continue at addresses 2..9 with no gaps or duplicates.
- num_samples=0, stop asserted after 600 accepted beats: beat 501 carries address 0 (m_desired 7500), m_last never set, done pulses after the held beat drains.
- rst asserted mid-RUN at beat 5: next cycle m_valid=0, busy=0, lut_addr=0, no done. A start asserted during RUN before the reset is ignored, with no restart.
- With LUT_STREAM_SIGNED_EN: address 0 gives all outputs 0; address 1 gives m_desired 188; address 12 gives m_ref -7380.
